// File: rtl/spi_cmd_arbiter_if.sv
// Requester-side and SPI-master-side signals of the command arbiter in one bundle.
// master = the arbiter; slave = requesters plus the SPI master top level.
interface spi_cmd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic                timeout_err;
  logic                busy;
  logic [31:0]         ep_dataout;
  logic                trigger;
  logic                hostinterrupt;

  modport master (
    input  req, req_data, hostinterrupt,
    output grant, done, timeout_err, busy, ep_dataout, trigger
  );

  modport slave (
    output req, req_data, hostinterrupt,
    input  grant, done, timeout_err, busy, ep_dataout, trigger
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin owner of the SPI master command port; a grant emits 4 words GAP cycles apart, then waits
// for hostinterrupt or TIMEOUT. No backpressure: requesters hold req, the SPI master never stalls trigger.
module spi_cmd_arbiter #(
  parameter int          N_REQ     = 4,
  parameter int          GAP       = 5,
  parameter int          TIMEOUT   = 1023,
  parameter logic [7:0]  DATA_ADDR = 8'h01,
  parameter logic [7:0]  CTRL_ADDR = 8'h41,
  parameter logic [15:0] GO_CTRL   = 16'h3710
) (
  input logic               clk,
  input logic               rst,
  spi_cmd_arbiter_if.master bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GAP);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [15:0]   cap;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    word_idx;
  logic [TW-1:0] timer;

  logic [PW-1:0] win;
  logic          win_found;
  logic [15:0]   win_data;
  int            idx;

  function automatic logic [31:0] seq_word(input logic [1:0] k, input logic [15:0] d);
    case (k)
      2'd0:    seq_word = {8'h80, 16'h0, DATA_ADDR};
      2'd1:    seq_word = {8'h40, 8'h0, d};
      2'd2:    seq_word = {8'h80, 16'h0, CTRL_ADDR};
      default: seq_word = {8'h40, 8'h0, GO_CTRL};
    endcase
  endfunction

  // Search upward from the last winner so a held request cannot starve the others.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win       = PW'(idx);
      end
    end
  end

  assign win_data = bus.req_data[16*int'(win) +: 16];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      ptr             <= PW'(N_REQ - 1);
      owner           <= '0;
      cap             <= '0;
      gap_cnt         <= '0;
      word_idx        <= '0;
      timer           <= '0;
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.timeout_err <= 1'b0;
      bus.busy        <= 1'b0;
      bus.trigger     <= 1'b0;
      bus.ep_dataout  <= '0;
    end else begin
      bus.trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            bus.grant      <= N_REQ'(1) << win;
            bus.busy       <= 1'b1;
            bus.trigger    <= 1'b1;
            bus.ep_dataout <= seq_word(2'd0, win_data);
            ptr            <= win;
            owner          <= win;
            cap            <= win_data;
            gap_cnt        <= '0;
            word_idx       <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // hostinterrupt here belongs to an earlier transfer and is deliberately ignored.
          if (word_idx == 2'd3) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (gap_cnt == GW'(GAP - 1)) begin
            gap_cnt        <= '0;
            word_idx       <= word_idx + 2'd1;
            bus.ep_dataout <= seq_word(word_idx + 2'd1, cap);
            bus.trigger    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (bus.hostinterrupt) begin
            bus.done <= N_REQ'(1) << owner;
            state    <= RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.done        <= N_REQ'(1) << owner;
            bus.timeout_err <= 1'b1;
            state           <= RELEASE;
          end
        end
        default: begin
          bus.grant       <= '0;
          bus.busy        <= 1'b0;
          bus.done        <= '0;
          bus.timeout_err <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule
